// File: rtl/data_island_packet_scheduler.sv
// Per-slot HDMI data-island packet scheduler: picks ACR, audio, AVI, SPD or NULL
// for each packet slot and returns one-cycle grants to the ACR and audio sources.
module data_island_packet_scheduler #(
  parameter int         AUDIO_PENDING_MAX = 7,
  parameter int         AUDIO_URGENT      = 4,
  parameter logic [1:0] INFOFRAME_ENABLE  = 2'b11,
  localparam int        CNT_W             = $clog2(AUDIO_PENDING_MAX + 1)
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             video_field_end,
  input  logic             packet_enable,
  input  logic             audio_sample_ready,
  input  logic             acr_tick,
  output logic [7:0]       packet_type,
  output logic             acr_grant,
  output logic             audio_grant,
  output logic [CNT_W-1:0] audio_pending,
  output logic             audio_overflow,
  output logic             infoframe_missed
);

  typedef enum logic [7:0] {
    PKT_NULL  = 8'h00,
    PKT_ACR   = 8'h01,
    PKT_AUDIO = 8'h02,
    PKT_AVI   = 8'h82,
    PKT_SPD   = 8'h83
  } pkt_t;

  localparam logic [CNT_W-1:0] URGENT_C = CNT_W'(AUDIO_URGENT);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(AUDIO_PENDING_MAX);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  pkt_t             packet_type_q, packet_type_d;
  logic             acr_grant_q, acr_grant_d;
  logic             audio_grant_q, audio_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             missed_q, missed_d;
  logic             acr_pending_q, acr_pending_d;
  logic             avi_sent_q, avi_sent_d;
  logic             spd_sent_q, spd_sent_d;

  pkt_t sel;
  logic decide;

  // Priority choice from the pre-edge state; only committed when a slot starts
  // without a coincident field end.
  always_comb begin
    sel = PKT_NULL;
    if (acr_pending_q)                             sel = PKT_ACR;
    else if (cnt_q >= URGENT_C)                    sel = PKT_AUDIO;
    else if (INFOFRAME_ENABLE[0] && !avi_sent_q)   sel = PKT_AVI;
    else if (INFOFRAME_ENABLE[1] && !spd_sent_q)   sel = PKT_SPD;
    else if (cnt_q != '0)                          sel = PKT_AUDIO;
  end

  assign decide = packet_enable && !video_field_end;

  always_comb begin
    packet_type_d = packet_type_q;
    acr_grant_d   = decide && (sel == PKT_ACR);
    audio_grant_d = decide && (sel == PKT_AUDIO);
    overflow_d    = overflow_q;
    cnt_d         = cnt_q;
    avi_sent_d    = avi_sent_q;
    spd_sent_d    = spd_sent_q;
    missed_d      = missed_q;

    if (packet_enable) packet_type_d = video_field_end ? PKT_NULL : sel;

    // A tick arriving with the grant re-arms the request for the next slot.
    acr_pending_d = acr_tick || (acr_pending_q && !acr_grant_d);

    case ({audio_sample_ready, audio_grant_d})
      2'b10: begin
        if (cnt_q == MAX_C) overflow_d = 1'b1;
        else                cnt_d      = cnt_q + ONE_C;
      end
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase

    if (video_field_end) begin
      if ((INFOFRAME_ENABLE[0] && !avi_sent_q) || (INFOFRAME_ENABLE[1] && !spd_sent_q))
        missed_d = 1'b1;
      avi_sent_d = 1'b0;
      spd_sent_d = 1'b0;
    end else if (decide) begin
      if (sel == PKT_AVI) avi_sent_d = 1'b1;
      if (sel == PKT_SPD) spd_sent_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      packet_type_q <= PKT_NULL;
      acr_grant_q   <= 1'b0;
      audio_grant_q <= 1'b0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      missed_q      <= 1'b0;
      acr_pending_q <= 1'b0;
      avi_sent_q    <= 1'b0;
      spd_sent_q    <= 1'b0;
    end else begin
      packet_type_q <= packet_type_d;
      acr_grant_q   <= acr_grant_d;
      audio_grant_q <= audio_grant_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      missed_q      <= missed_d;
      acr_pending_q <= acr_pending_d;
      avi_sent_q    <= avi_sent_d;
      spd_sent_q    <= spd_sent_d;
    end
  end

  assign packet_type      = packet_type_q;
  assign acr_grant        = acr_grant_q;
  assign audio_grant      = audio_grant_q;
  assign audio_pending    = cnt_q;
  assign audio_overflow   = overflow_q;
  assign infoframe_missed = missed_q;

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Bench for data_island_packet_scheduler: directed scenarios plus randomized
// traffic checked against a slot-level reference model.
module tb_data_island_packet_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b0;
  logic       video_field_end = 1'b0;
  logic       packet_enable = 1'b0;
  logic       audio_sample_ready = 1'b0;
  logic       acr_tick = 1'b0;
  logic [7:0] packet_type;
  logic       acr_grant;
  logic       audio_grant;
  logic [2:0] audio_pending;
  logic       audio_overflow;
  logic       infoframe_missed;

  int checks = 0;
  int errors = 0;

  data_island_packet_scheduler #(
    .AUDIO_PENDING_MAX(7),
    .AUDIO_URGENT(4),
    .INFOFRAME_ENABLE(2'b11)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .video_field_end(video_field_end),
    .packet_enable(packet_enable),
    .audio_sample_ready(audio_sample_ready),
    .acr_tick(acr_tick),
    .packet_type(packet_type),
    .acr_grant(acr_grant),
    .audio_grant(audio_grant),
    .audio_pending(audio_pending),
    .audio_overflow(audio_overflow),
    .infoframe_missed(infoframe_missed)
  );

  always #5 clk_pixel = ~clk_pixel;

  // One clock: inputs applied before the edge, released 1 ns after it.
  task automatic cyc(input logic pe, input logic fe, input logic tick,
                     input logic rdy, input logic rs);
    packet_enable      = pe;
    video_field_end    = fe;
    acr_tick           = tick;
    audio_sample_ready = rdy;
    reset              = rs;
    @(posedge clk_pixel);
    #1;
    packet_enable      = 1'b0;
    video_field_end    = 1'b0;
    acr_tick           = 1'b0;
    audio_sample_ready = 1'b0;
    reset              = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({packet_type, acr_grant, audio_grant, audio_pending, audio_overflow, infoframe_missed} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got type=%h acr=%b aud=%b pend=%0d ovf=%b miss=%b, want all 0",
               packet_type, acr_grant, audio_grant, audio_pending, audio_overflow, infoframe_missed);
    end
  endtask

  task automatic test_infoframes();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h82 || acr_grant !== 1'b0 || audio_grant !== 1'b0) begin
      errors++;
      $display("FAIL if_avi: got type=%h acr=%b aud=%b, want 82 0 0", packet_type, acr_grant, audio_grant);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h82) begin
      errors++;
      $display("FAIL if_hold: got type=%h, want 82", packet_type);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h83) begin
      errors++;
      $display("FAIL if_spd: got type=%h, want 83", packet_type);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h00 || acr_grant !== 1'b0 || audio_grant !== 1'b0) begin
      errors++;
      $display("FAIL if_null: got type=%h acr=%b aud=%b, want 00 0 0", packet_type, acr_grant, audio_grant);
    end
  endtask

  task automatic test_audio_low();
    logic [2:0] want;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h83 || audio_pending !== 3'd3) begin
      errors++;
      $display("FAIL low_spd: got type=%h pend=%0d, want 83 3", packet_type, audio_pending);
    end
    want = 3'd3;
    for (int i = 0; i < 3; i++) begin
      want = want - 3'd1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (packet_type !== 8'h02 || audio_grant !== 1'b1 || audio_pending !== want) begin
        errors++;
        $display("FAIL low_audio%0d: got type=%h aud=%b pend=%0d, want 02 1 %0d",
                 i, packet_type, audio_grant, audio_pending, want);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (audio_grant !== 1'b0) begin
        errors++;
        $display("FAIL low_pulse%0d: got aud=%b, want 0", i, audio_grant);
      end
    end
  endtask

  task automatic test_acr_urgent();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h01 || acr_grant !== 1'b1 || audio_grant !== 1'b0 || audio_pending !== 3'd5) begin
      errors++;
      $display("FAIL urg_acr: got type=%h acr=%b aud=%b pend=%0d, want 01 1 0 5",
               packet_type, acr_grant, audio_grant, audio_pending);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h02 || acr_grant !== 1'b0 || audio_pending !== 3'd4) begin
      errors++;
      $display("FAIL urg_aud1: got type=%h acr=%b pend=%0d, want 02 0 4", packet_type, acr_grant, audio_pending);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h02 || audio_pending !== 3'd3) begin
      errors++;
      $display("FAIL urg_aud2: got type=%h pend=%0d, want 02 3", packet_type, audio_pending);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h82 || audio_grant !== 1'b0 || audio_pending !== 3'd3) begin
      errors++;
      $display("FAIL urg_avi: got type=%h aud=%b pend=%0d, want 82 0 3", packet_type, audio_grant, audio_pending);
    end
  endtask

  task automatic test_overflow();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (audio_pending !== 3'd7 || audio_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: got pend=%0d ovf=%b, want 7 0", audio_pending, audio_overflow);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (audio_pending !== 3'd7 || audio_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got pend=%0d ovf=%b, want 7 1", audio_pending, audio_overflow);
    end
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (audio_pending !== 3'd0 || audio_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got pend=%0d ovf=%b, want 0 1", audio_pending, audio_overflow);
    end
  endtask

  task automatic test_field_end();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h00 || acr_grant !== 1'b0 || audio_grant !== 1'b0 || infoframe_missed !== 1'b1) begin
      errors++;
      $display("FAIL fe_slot: got type=%h acr=%b aud=%b miss=%b, want 00 0 0 1",
               packet_type, acr_grant, audio_grant, infoframe_missed);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (packet_type !== 8'h82 || infoframe_missed !== 1'b1) begin
      errors++;
      $display("FAIL fe_next: got type=%h miss=%b, want 82 1", packet_type, infoframe_missed);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (packet_type !== 8'h02 || audio_grant !== 1'b1 || audio_pending !== 3'd2) begin
      errors++;
      $display("FAIL b2b_same: got type=%h aud=%b pend=%0d, want 02 1 2", packet_type, audio_grant, audio_pending);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({packet_type, acr_grant, audio_grant, audio_pending, audio_overflow, infoframe_missed} !== 15'd0) begin
      errors++;
      $display("FAIL b2b_reset: got type=%h acr=%b aud=%b pend=%0d ovf=%b miss=%b, want all 0",
               packet_type, acr_grant, audio_grant, audio_pending, audio_overflow, infoframe_missed);
    end
  endtask

  // Reference: slot priority expressed directly as a list of owed packets.
  function automatic int pick(int acr, int cnt, int avi, int spd);
    if (acr != 0)  return 'h01;
    if (cnt >= 4)  return 'h02;
    if (avi == 0)  return 'h82;
    if (spd == 0)  return 'h83;
    if (cnt > 0)   return 'h02;
    return 'h00;
  endfunction

  task automatic test_random();
    int m_type, m_acr, m_cnt, m_avi, m_spd, m_acrg, m_audg, m_ovf, m_miss;
    int rdy_pct;
    logic pe, fe, tick, rdy, rs;
    int t;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_type = 0; m_acr = 0; m_cnt = 0; m_avi = 0; m_spd = 0;
    m_acrg = 0; m_audg = 0; m_ovf = 0; m_miss = 0;
    rdy_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) rdy_pct = $urandom_range(10, 80);
      pe   = ($urandom_range(0, 99) < 35);
      fe   = ($urandom_range(0, 99) < 3);
      tick = ($urandom_range(0, 99) < 8);
      rdy  = ($urandom_range(0, 99) < rdy_pct);
      rs   = ($urandom_range(0, 999) < 3);
      cyc(pe, fe, tick, rdy, rs);
      if (rs) begin
        m_type = 0; m_acr = 0; m_cnt = 0; m_avi = 0; m_spd = 0;
        m_acrg = 0; m_audg = 0; m_ovf = 0; m_miss = 0;
      end else begin
        t = pick(m_acr, m_cnt, m_avi, m_spd);
        m_acrg = (pe && !fe && t == 'h01) ? 1 : 0;
        m_audg = (pe && !fe && t == 'h02) ? 1 : 0;
        if (pe) m_type = fe ? 0 : t;
        if (tick) m_acr = 1;
        else if (m_acrg != 0) m_acr = 0;
        m_cnt = m_cnt + int'(rdy) - m_audg;
        if (m_cnt > 7) begin
          m_cnt = 7;
          m_ovf = 1;
        end
        if (fe) begin
          if (m_avi == 0 || m_spd == 0) m_miss = 1;
          m_avi = 0;
          m_spd = 0;
        end else if (pe) begin
          if (t == 'h82) m_avi = 1;
          if (t == 'h83) m_spd = 1;
        end
      end
      checks++;
      if (packet_type !== 8'(m_type) || acr_grant !== 1'(m_acrg) || audio_grant !== 1'(m_audg) ||
          audio_pending !== 3'(m_cnt) || audio_overflow !== 1'(m_ovf) || infoframe_missed !== 1'(m_miss)) begin
        errors++;
        $display("FAIL rand@%0d: got type=%h acr=%b aud=%b pend=%0d ovf=%b miss=%b, want %h %0d %0d %0d %0d %0d",
                 n, packet_type, acr_grant, audio_grant, audio_pending, audio_overflow, infoframe_missed,
                 m_type, m_acrg, m_audg, m_cnt, m_ovf, m_miss);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_infoframes();
    test_audio_low();
    test_acr_urgent();
    test_overflow();
    test_field_end();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
